// File: rtl/conv_first_to_last_with_ready.sv
// Converts a first-framed stream into a last-framed stream with valid/ready on both sides.
// Each beat waits in a hold register until its last flag is known, then enters a fall-through FIFO.
module conv_first_to_last_with_ready #(
    parameter int width        = 8,
    parameter int depth        = 4,
    parameter int idle_timeout = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic             up_first,
    input  logic [width-1:0] up_data,
    output logic             down_valid,
    input  logic             down_ready,
    output logic             down_last,
    output logic [width-1:0] down_data
);
    localparam int addr_w = $clog2(depth);
    localparam int ptr_w  = addr_w + 1;
    localparam int cnt_w  = (idle_timeout > 0) ? $clog2(idle_timeout + 1) : 1;
    localparam logic [cnt_w-1:0] timeout_val = cnt_w'(idle_timeout);
    localparam logic             timeout_en  = (idle_timeout != 0);

    logic             hold_valid_r;
    logic [width-1:0] hold_data_r;
    logic             pending_flush_r;
    logic [cnt_w-1:0] idle_cnt_r;
    logic [ptr_w-1:0] wr_ptr_r;
    logic [ptr_w-1:0] rd_ptr_r;
    logic [width-1:0] mem_data_r [depth];
    logic             mem_last_r [depth];

    logic fifo_empty_s;
    logic fifo_full_s;
    logic accept_s;
    logic timeout_hit_s;
    logic close_s;
    logic close_push_s;
    logic push_s;
    logic push_last_s;
    logic pop_s;

    // Handshake, close and push/pop decisions from registered state
    always_comb begin
        fifo_empty_s  = (wr_ptr_r == rd_ptr_r);
        fifo_full_s   = (wr_ptr_r[ptr_w-1] != rd_ptr_r[ptr_w-1]) &&
                        (wr_ptr_r[addr_w-1:0] == rd_ptr_r[addr_w-1:0]);
        up_ready      = !hold_valid_r || !fifo_full_s;
        accept_s      = up_valid && up_ready;
        timeout_hit_s = timeout_en && (idle_cnt_r == timeout_val);
        close_s       = flush || pending_flush_r || timeout_hit_s;
        close_push_s  = !accept_s && hold_valid_r && close_s && !fifo_full_s;
        push_s        = (accept_s && hold_valid_r) || close_push_s;
        // A successor beat decides the last flag unless a close is also requested
        if (accept_s) begin
            push_last_s = up_first || close_s;
        end else begin
            push_last_s = 1'b1;
        end
        pop_s      = !fifo_empty_s && down_ready;
        down_valid = !fifo_empty_s;
        down_data  = mem_data_r[rd_ptr_r[addr_w-1:0]];
        down_last  = mem_last_r[rd_ptr_r[addr_w-1:0]];
    end

    // Hold register: always holds the most recently accepted beat until it is pushed
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_valid_r <= 1'b0;
            hold_data_r  <= {width{1'b0}};
        end else if (accept_s) begin
            hold_valid_r <= 1'b1;
            hold_data_r  <= up_data;
        end else if (close_push_s) begin
            hold_valid_r <= 1'b0;
        end
    end

    // Flush that arrives while the FIFO is full waits here until the held beat is pushed
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_flush_r <= 1'b0;
        end else if (push_s) begin
            pending_flush_r <= 1'b0;
        end else if (flush && hold_valid_r && fifo_full_s) begin
            pending_flush_r <= 1'b1;
        end
    end

    // Idle counter: saturating count of cycles the held beat waits without a successor
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_cnt_r <= {cnt_w{1'b0}};
        end else if (accept_s || close_push_s || !hold_valid_r) begin
            idle_cnt_r <= {cnt_w{1'b0}};
        end else if (idle_cnt_r != timeout_val) begin
            idle_cnt_r <= idle_cnt_r + cnt_w'(1);
        end
    end

    // Output FIFO storage and pointers; the extra pointer bit separates full from empty
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {ptr_w{1'b0}};
            rd_ptr_r <= {ptr_w{1'b0}};
            for (int i = 0; i < depth; i++) begin
                mem_data_r[i] <= {width{1'b0}};
                mem_last_r[i] <= 1'b0;
            end
        end else begin
            if (push_s) begin
                mem_data_r[wr_ptr_r[addr_w-1:0]] <= hold_data_r;
                mem_last_r[wr_ptr_r[addr_w-1:0]] <= push_last_s;
                wr_ptr_r                         <= wr_ptr_r + ptr_w'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ptr_w'(1);
            end
        end
    end
endmodule

// File: tb/tb_conv_first_to_last_with_ready.sv
// Bench for conv_first_to_last_with_ready: queue-based reference model checked every cycle,
// directed packet scenarios with literal expectations, then randomized traffic.
module tb_conv_first_to_last_with_ready;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int IT = 16;

    logic         clock      = 1'b0;
    logic         reset      = 1'b1;
    logic         flush      = 1'b0;
    logic         up_valid   = 1'b0;
    logic         up_first   = 1'b0;
    logic [W-1:0] up_data    = '0;
    logic         down_ready = 1'b0;
    logic         up_ready;
    logic         down_valid;
    logic         down_last;
    logic [W-1:0] down_data;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Reference model state: queued output beats as {last, data}
    logic [W:0]   mq [$];
    logic [W:0]   log_q [$];
    logic [W:0]   head;
    bit           m_hold_v;
    logic [W-1:0] m_hold_d;
    bit           m_pend;
    int           m_idle;
    bit           m_acc;

    conv_first_to_last_with_ready #(.width(W), .depth(D), .idle_timeout(IT)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .up_valid(up_valid), .up_ready(up_ready), .up_first(up_first), .up_data(up_data),
        .down_valid(down_valid), .down_ready(down_ready), .down_last(down_last), .down_data(down_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W:0] log_at(input int i);
        if (i < log_q.size()) return log_q[i];
        return {(W+1){1'bx}};
    endfunction

    // Advance the model by one rising edge from the inputs presented during the cycle
    task automatic model_step();
        bit full, acc, cls, cpush;
        m_acc = 1'b0;
        if (reset) begin
            mq.delete();
            m_hold_v = 1'b0;
            m_hold_d = '0;
            m_pend   = 1'b0;
            m_idle   = 0;
            return;
        end
        full  = (mq.size() == D);
        acc   = up_valid && (!m_hold_v || !full);
        cls   = flush || m_pend || (IT != 0 && m_idle == IT);
        cpush = !acc && m_hold_v && cls && !full;
        if (mq.size() > 0 && down_ready) void'(mq.pop_front());
        if (acc && m_hold_v) begin
            mq.push_back({up_first | cls, m_hold_d});
            m_pend = 1'b0;
        end else if (cpush) begin
            mq.push_back({1'b1, m_hold_d});
            m_pend = 1'b0;
        end else if (flush && m_hold_v) begin
            m_pend = 1'b1;
        end
        if (acc || cpush || !m_hold_v) m_idle = 0;
        else if (m_idle < IT) m_idle++;
        if (acc) begin
            m_hold_v = 1'b1;
            m_hold_d = up_data;
        end else if (cpush) begin
            m_hold_v = 1'b0;
        end
        m_acc = acc;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input bit f);
        int n = 0;
        up_valid = 1'b1;
        up_data  = d;
        up_first = f;
        do begin
            tick();
            n++;
        end while (!m_acc && n < 50);
        check("send_accepted", {31'd0, m_acc}, 32'd1);
        up_valid = 1'b0;
        up_first = 1'b0;
    endtask

    // Compare DUT outputs against the model every cycle, mid-way between rising edges
    always @(negedge clock) begin
        if (check_en && !reset) begin
            check("up_ready", {31'd0, up_ready}, {31'd0, (!m_hold_v || mq.size() < D)});
            check("down_valid", {31'd0, down_valid}, {31'd0, (mq.size() > 0)});
            if (mq.size() > 0) begin
                head = mq[0];
                check("down_data", {24'd0, down_data}, {24'd0, head[W-1:0]});
                check("down_last", {31'd0, down_last}, {31'd0, head[W]});
                if (down_ready && down_valid) log_q.push_back({down_last, down_data});
            end
        end
    end

    initial begin
        int acc_n;
        int n;
        int pv_tab [4] = '{85, 50, 8, 2};
        int pr_tab [4] = '{90, 30, 60, 10};
        int pv;
        int pr;

        repeat (2) tick();
        check("rst_down_valid", {31'd0, down_valid}, 32'd0);
        check("rst_down_last", {31'd0, down_last}, 32'd0);
        check("rst_down_data", {24'd0, down_data}, 32'd0);
        check("rst_up_ready", {31'd0, up_ready}, 32'd1);
        reset      = 1'b0;
        check_en   = 1'b1;
        down_ready = 1'b1;
        tick();

        // Three-beat packet A closed by the first beat of packet B
        log_q.delete();
        send(8'hA0, 1'b1); send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hB0, 1'b1);
        repeat (3) tick();
        check("A_count", log_q.size(), 32'd3);
        check("A0", {23'd0, log_at(0)}, {23'd0, 1'b0, 8'hA0});
        check("A1", {23'd0, log_at(1)}, {23'd0, 1'b0, 8'hA1});
        check("A2", {23'd0, log_at(2)}, {23'd0, 1'b1, 8'hA2});
        check("B0_still_held", {31'd0, down_valid}, 32'd0);
        flush = 1'b1; tick(); flush = 1'b0;
        check("B0_flushed", {23'd0, down_last, down_data}, {23'd0, 1'b1, 8'hB0});
        repeat (2) tick();

        // Single-beat packets; the last one leaves one cycle after a flush pulse
        log_q.delete();
        send(8'hC0, 1'b1); send(8'hD0, 1'b1); send(8'hE0, 1'b1);
        repeat (2) tick();
        check("CD_count", log_q.size(), 32'd2);
        check("C", {23'd0, log_at(0)}, {23'd0, 1'b1, 8'hC0});
        check("D", {23'd0, log_at(1)}, {23'd0, 1'b1, 8'hD0});
        check("E_not_yet", {31'd0, down_valid}, 32'd0);
        flush = 1'b1; tick(); flush = 1'b0;
        check("E_valid", {31'd0, down_valid}, 32'd1);
        check("E", {23'd0, down_last, down_data}, {23'd0, 1'b1, 8'hE0});
        repeat (2) tick();

        // Idle timeout closes the final beat 17 cycles after its acceptance
        send(8'h58, 1'b1); send(8'h59, 1'b0);
        check("X0", {22'd0, down_valid, down_last, down_data}, {22'd0, 1'b1, 1'b0, 8'h58});
        n = 0;
        do begin
            tick();
            n++;
        end while (!down_valid && n < 40);
        check("X1_timeout_latency", n, 32'd17);
        check("X1", {23'd0, down_last, down_data}, {23'd0, 1'b1, 8'h59});
        repeat (2) tick();

        // Backpressure: hold plus four FIFO entries, then up_ready drops
        log_q.delete();
        down_ready = 1'b0;
        acc_n = 0;
        for (int i = 0; i < 6; i++) begin
            up_valid = 1'b1;
            up_data  = 8'(8'h60 + i);
            up_first = (i == 0);
            tick();
            if (m_acc) acc_n++;
            else break;
        end
        check("bp_accepts", acc_n, 32'd5);
        check("bp_up_ready", {31'd0, up_ready}, 32'd0);
        down_ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_acc && n < 20);
        check("bp_sixth_accepted", {31'd0, m_acc}, 32'd1);
        up_valid = 1'b0;
        up_first = 1'b0;
        flush = 1'b1; tick(); flush = 1'b0;
        repeat (8) tick();
        check("bp_count", log_q.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check("bp_order", {23'd0, log_at(i)}, {23'd0, (i == 5), 8'(8'h60 + i)});
        end

        // Flush while the FIFO is full waits for a free slot
        log_q.delete();
        down_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(8'(8'h70 + i), (i == 0));
        check("ff_up_ready", {31'd0, up_ready}, 32'd0);
        flush = 1'b1; tick(); flush = 1'b0;
        repeat (2) tick();
        check("ff_nothing_out", log_q.size(), 32'd0);
        down_ready = 1'b1; tick(); down_ready = 1'b0;
        repeat (3) tick();
        down_ready = 1'b1;
        repeat (8) tick();
        check("ff_count", log_q.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("ff_order", {23'd0, log_at(i)}, {23'd0, (i == 4), 8'(8'h70 + i)});
        end

        // Asynchronous reset with three beats queued and one held
        down_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'(8'h80 + i), (i == 0));
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_down_valid", {31'd0, down_valid}, 32'd0);
        check("mid_rst_up_ready", {31'd0, up_ready}, 32'd1);
        check("mid_rst_down_data", {23'd0, down_last, down_data}, 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        log_q.delete();
        down_ready = 1'b1;
        send(8'h90, 1'b1); send(8'h91, 1'b0);
        flush = 1'b1; tick(); flush = 1'b0;
        repeat (4) tick();
        check("post_rst_count", log_q.size(), 32'd2);
        check("post_rst_P0", {23'd0, log_at(0)}, {23'd0, 1'b0, 8'h90});
        check("post_rst_P1", {23'd0, log_at(1)}, {23'd0, 1'b1, 8'h91});

        // Randomized traffic with phases of varying load and backpressure
        pv = pv_tab[0];
        pr = pr_tab[0];
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                pv = pv_tab[(c / 250) % 4];
                pr = pr_tab[(c / 1000) % 4];
            end
            up_valid   = ($urandom_range(0, 99) < pv);
            up_first   = ($urandom_range(0, 99) < 30);
            up_data    = 8'($urandom);
            down_ready = ($urandom_range(0, 99) < pr);
            flush      = ($urandom_range(0, 99) < 3);
            tick();
        end
        up_valid   = 1'b0;
        flush      = 1'b0;
        down_ready = 1'b1;
        repeat (25) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
